// File: rtl/dom_and_scheduler.sv
// ---------------------------------------------------------------------------
// dom_and_scheduler
//
// Shares one W-bit first-order DOM AND gadget between N_REQ requesters of
// masked AND operations. Requesters are served round-robin. Each operation
// uses one fresh randomness word. Every operation is tracked through the
// gadget's fixed latency and the two-share result is parked in a per-requester
// response buffer until the requester takes it.
//
// Ports
//   clock_0, reset_0          : rising-edge clock, async active-low reset
//   req_valid / req_ready     : per-requester operation handshake
//   req_{a,b}_s{0,1}          : operand shares, requester i in [i*W +: W]
//   rand_valid / rand_ready   : randomness handshake, rand_bits is the word
//   g_i{0,1}_s{0,1}, g_rand   : operands and randomness driven to the gadget
//   g_o0_s{0,1}               : gadget result shares, valid LAT edges later
//   rsp_valid / rsp_ready     : per-requester result handshake
//   rsp_s{0,1}                : result shares, same packing as requests
// ---------------------------------------------------------------------------
module dom_and_scheduler #(
   parameter int N_REQ = 4,
   parameter int W     = 8,
   parameter int LAT   = 1
) (
   input  logic               clock_0,
   input  logic               reset_0,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a_s0,
   input  logic [N_REQ*W-1:0] req_a_s1,
   input  logic [N_REQ*W-1:0] req_b_s0,
   input  logic [N_REQ*W-1:0] req_b_s1,
   input  logic               rand_valid,
   output logic               rand_ready,
   input  logic [W-1:0]       rand_bits,
   output logic [W-1:0]       g_i0_s0,
   output logic [W-1:0]       g_i0_s1,
   output logic [W-1:0]       g_i1_s0,
   output logic [W-1:0]       g_i1_s1,
   output logic [W-1:0]       g_rand,
   input  logic [W-1:0]       g_o0_s0,
   input  logic [W-1:0]       g_o0_s1,
   output logic [N_REQ-1:0]   rsp_valid,
   input  logic [N_REQ-1:0]   rsp_ready,
   output logic [N_REQ*W-1:0] rsp_s0,
   output logic [N_REQ*W-1:0] rsp_s1
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   busy_q, busy_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [LAT-1:0]     tag_vld_q, tag_vld_d;
   logic [PW-1:0]      tag_id_q [LAT];
   logic [PW-1:0]      tag_id_d [LAT];
   logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [N_REQ*W-1:0] rsp_s0_q, rsp_s0_d;
   logic [N_REQ*W-1:0] rsp_s1_q, rsp_s1_d;

   logic [N_REQ-1:0]   eligible;
   logic [N_REQ-1:0]   grant_oh;
   logic [N_REQ-1:0]   rsp_hs;
   logic [PW-1:0]      grant_idx;
   logic [PW:0]        idx_w;
   logic               found;
   logic               issue;
   logic               ret_vld;
   logic [PW-1:0]      ret_id;

   // Round-robin search from ptr upward with wrap. The extra bit on idx_w
   // holds ptr+k before it is folded back below N_REQ. Issue is gated by
   // reset_0 so nothing is handed out while reset is held.
   always_comb begin
      eligible  = req_valid & ~busy_q;
      found     = 1'b0;
      grant_idx = '0;
      idx_w     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx_w = {1'b0, ptr_q} + (PW+1)'(k);
         if (idx_w >= (PW+1)'(N_REQ)) begin
            idx_w = idx_w - (PW+1)'(N_REQ);
         end
         if (!found && eligible[idx_w[PW-1:0]]) begin
            found     = 1'b1;
            grant_idx = idx_w[PW-1:0];
         end
      end
      issue = reset_0 & found & rand_valid;
      for (int i = 0; i < N_REQ; i++) begin
         grant_oh[i] = issue && (grant_idx == PW'(i));
      end
   end

   assign req_ready  = grant_oh;
   assign rand_ready = issue;
   assign g_rand     = {W{issue}} & rand_bits;

   // Share-0 operand selection: its own one-hot AND-OR tree, all zero when
   // nothing is granted.
   always_comb begin
      g_i0_s0 = '0;
      g_i1_s0 = '0;
      for (int i = 0; i < N_REQ; i++) begin
         g_i0_s0 = g_i0_s0 | ({W{grant_oh[i]}} & req_a_s0[i*W +: W]);
         g_i1_s0 = g_i1_s0 | ({W{grant_oh[i]}} & req_b_s0[i*W +: W]);
      end
   end

   // Share-1 operand selection, physically separate from share 0 so the two
   // shares never meet in one gate.
   always_comb begin
      g_i0_s1 = '0;
      g_i1_s1 = '0;
      for (int i = 0; i < N_REQ; i++) begin
         g_i0_s1 = g_i0_s1 | ({W{grant_oh[i]}} & req_a_s1[i*W +: W]);
         g_i1_s1 = g_i1_s1 | ({W{grant_oh[i]}} & req_b_s1[i*W +: W]);
      end
   end

   // Busy, pointer and tag pipeline. Busy is cleared only by the response
   // handshake, and eligibility reads the registered value, so a released
   // requester can be granted no earlier than the following cycle.
   always_comb begin
      rsp_hs    = rsp_valid_q & rsp_ready;
      busy_d    = (busy_q | grant_oh) & ~rsp_hs;
      ptr_d     = ptr_q;
      if (issue) begin
         ptr_d = (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + PW'(1);
      end
      tag_vld_d    = tag_vld_q;
      tag_id_d     = tag_id_q;
      tag_vld_d[0] = issue;
      tag_id_d[0]  = grant_idx;
      for (int k = 1; k < LAT; k++) begin
         tag_vld_d[k] = tag_vld_q[k-1];
         tag_id_d[k]  = tag_id_q[k-1];
      end
      ret_vld = tag_vld_q[LAT-1];
      ret_id  = tag_id_q[LAT-1];
   end

   // Response valid bits: clear on handshake, set when the tag returns.
   always_comb begin
      rsp_valid_d = rsp_valid_q & ~rsp_hs;
      for (int i = 0; i < N_REQ; i++) begin
         if (ret_vld && ret_id == PW'(i)) begin
            rsp_valid_d[i] = 1'b1;
         end
      end
   end

   // Share-0 response buffers: wiped on handshake, loaded on return.
   always_comb begin
      rsp_s0_d = rsp_s0_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (rsp_hs[i]) begin
            rsp_s0_d[i*W +: W] = '0;
         end
         if (ret_vld && ret_id == PW'(i)) begin
            rsp_s0_d[i*W +: W] = g_o0_s0;
         end
      end
   end

   // Share-1 response buffers, kept apart from share 0.
   always_comb begin
      rsp_s1_d = rsp_s1_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (rsp_hs[i]) begin
            rsp_s1_d[i*W +: W] = '0;
         end
         if (ret_vld && ret_id == PW'(i)) begin
            rsp_s1_d[i*W +: W] = g_o0_s1;
         end
      end
   end

   // State registers. Reset drops everything in flight, so late gadget
   // results of dropped operations find no valid tag and are ignored.
   always_ff @(posedge clock_0 or negedge reset_0) begin
      if (!reset_0) begin
         busy_q      <= '0;
         ptr_q       <= '0;
         tag_vld_q   <= '0;
         for (int k = 0; k < LAT; k++) begin
            tag_id_q[k] <= '0;
         end
         rsp_valid_q <= '0;
         rsp_s0_q    <= '0;
         rsp_s1_q    <= '0;
      end else begin
         busy_q      <= busy_d;
         ptr_q       <= ptr_d;
         tag_vld_q   <= tag_vld_d;
         for (int k = 0; k < LAT; k++) begin
            tag_id_q[k] <= tag_id_d[k];
         end
         rsp_valid_q <= rsp_valid_d;
         rsp_s0_q    <= rsp_s0_d;
         rsp_s1_q    <= rsp_s1_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_s0    = rsp_s0_q;
   assign rsp_s1    = rsp_s1_q;

endmodule
